// File: rtl/aac_pcm_pkg.sv
// Shared constants and types for the AAC decoder PCM output stage.
// Holds sample width, lanes per beat, default frame length, serializer states.
package aac_pcm_pkg;

    localparam int wordLength         = 16;
    localparam int lanesPerBeat       = 4;
    localparam int defaultFrameLength = 1024;

    typedef enum logic {
        IDLE,
        SHIFT
    } ser_state_t;

endpackage

// File: rtl/pcm_fifo.sv
// Synchronous beat FIFO with wrap-around pointers one bit wider than the index.
// Ports: clock, reset, push, pop, din, dout (head, combinational), full, empty.
module pcm_fifo #(
    parameter int width = 64,
    parameter int depth = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW:0]      wp;
    logic [AW:0]      rp;
    logic             doPush;
    logic             doPop;

    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    // Same index with differing wrap bits means the writer lapped the reader.
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (doPush) wp <= wp + 1'b1;
            if (doPop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pcm_output_buffer.sv
// AAC PCM output stage: buffers 4-sample beats, serializes one sample per cycle.
// Ports: clock, reset, inValid/inReady/dataBusIn (beats in), pcmOut/pcmValid/
// pcmReady (samples out), frameEnd, overflow; dropCount when PCM_DROP_COUNT_EN.
module pcm_output_buffer
    import aac_pcm_pkg::*;
#(
    parameter int fifoDepth   = 8,
    parameter int frameLength = defaultFrameLength
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                inValid,
    output logic                                inReady,
    input  logic [lanesPerBeat*wordLength-1:0]  dataBusIn,
    output logic [wordLength-1:0]               pcmOut,
    output logic                                pcmValid,
    input  logic                                pcmReady,
    output logic                                frameEnd,
`ifdef PCM_DROP_COUNT_EN
    output logic [7:0]                          dropCount,
`endif
    output logic                                overflow
);

    localparam int busSize = lanesPerBeat * wordLength;
    localparam int FW      = $clog2(frameLength);

    ser_state_t         state;
    logic [busSize-1:0] shiftReg;
    logic [1:0]         lane;
    logic [FW-1:0]      frameCnt;
    logic [busSize-1:0] head;
    logic               full;
    logic               empty;
    logic               pop;
    logic               hs;

    pcm_fifo #(
        .width (busSize),
        .depth (fifoDepth)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (inValid),
        .pop   (pop),
        .din   (dataBusIn),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign inReady  = !full;
    assign pcmValid = (state == SHIFT);
    assign hs       = pcmValid && pcmReady;
    assign pcmOut   = shiftReg[lane*wordLength +: wordLength];
    assign frameEnd = pcmValid && (frameCnt == FW'(frameLength - 1));

    // Reload on idle, or on the last lane's handshake so beats run with no bubble.
    assign pop = !empty &&
                 ((state == IDLE) || (hs && lane == 2'd3));

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            shiftReg <= '0;
            lane     <= '0;
            frameCnt <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= inValid && full;
            if (pop) shiftReg <= head;
            unique case (state)
                IDLE: begin
                    lane <= '0;
                    if (!empty) state <= SHIFT;
                end
                SHIFT: begin
                    if (pcmReady) begin
                        lane     <= lane + 2'd1;
                        frameCnt <= frameEnd ? '0 : frameCnt + FW'(1);
                        if (lane == 2'd3 && empty) state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef PCM_DROP_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            dropCount <= '0;
        end else if (inValid && full && dropCount != 8'hFF) begin
            dropCount <= dropCount + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pcm_output_buffer.sv
// Directed testbench for pcm_output_buffer.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_pcm_output_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [63:0] dataBusIn;
    logic [15:0] pcmOut;
    logic        pcmValid;
    logic        pcmReady;
    logic        frameEnd;
    logic        overflow;
`ifdef PCM_DROP_COUNT_EN
    logic [7:0]  dropCount;
`endif

    int checks = 0;
    int failures = 0;

    pcm_output_buffer dut (
        .clock     (clock),
        .reset     (reset),
        .inValid   (inValid),
        .inReady   (inReady),
        .dataBusIn (dataBusIn),
        .pcmOut    (pcmOut),
        .pcmValid  (pcmValid),
        .pcmReady  (pcmReady),
        .frameEnd  (frameEnd),
`ifdef PCM_DROP_COUNT_EN
        .dropCount (dropCount),
`endif
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Beat b carries samples 4b+1 .. 4b+4 on lanes 0..3.
    function automatic logic [63:0] beat(input int b);
        logic [63:0] v;
        for (int k = 0; k < 4; k++) v[k*16 +: 16] = 16'(b*4 + k + 1);
        return v;
    endfunction

    task automatic do_reset;
        reset = 1'b1;
        inValid = 1'b0;
        pcmReady = 1'b0;
        dataBusIn = '0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if (pcmValid !== 1'b0) begin
            failures++;
            $display("FAIL reset_pcmValid got %b want 0", pcmValid);
        end
        checks++;
        if (inReady !== 1'b1) begin
            failures++;
            $display("FAIL reset_inReady got %b want 1", inReady);
        end
        checks++;
        if ({frameEnd, overflow} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags got %b%b want 00", frameEnd, overflow);
        end
        checks++;
        if (pcmOut !== 16'h0) begin
            failures++;
            $display("FAIL reset_pcmOut got %h want 0000", pcmOut);
        end
    endtask

    task automatic test_single;
        pcmReady = 1'b1;
        inValid = 1'b1;
        dataBusIn = 64'h0004_0003_0002_0001;
        tick;
        inValid = 1'b0;
        checks++;
        if (pcmValid !== 1'b0) begin
            failures++;
            $display("FAIL single_n1_valid got %b want 0", pcmValid);
        end
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++;
            if ({pcmValid, pcmOut} !== {1'b1, 16'(k + 1)}) begin
                failures++;
                $display("FAIL single_lane%0d got v=%b d=%h want v=1 d=%h",
                         k, pcmValid, pcmOut, 16'(k + 1));
            end
        end
        tick;
        checks++;
        if (pcmValid !== 1'b0) begin
            failures++;
            $display("FAIL single_end_valid got %b want 0", pcmValid);
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] exp;
        do_reset;
        pcmReady = 1'b1;
        inValid = 1'b1;
        dataBusIn = 64'h0008_0007_0006_0005;
        tick;
        inValid = 1'b0;
        tick;
        tick;
        pcmReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++;
            if ({pcmValid, pcmOut} !== {1'b1, 16'h6}) begin
                failures++;
                $display("FAIL stall_hold%0d got v=%b d=%h want v=1 d=0006",
                         i, pcmValid, pcmOut);
            end
        end
        pcmReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp = 16'(7 + i);
            tick;
            checks++;
            if (i < 2 && {pcmValid, pcmOut} !== {1'b1, exp}) begin
                failures++;
                $display("FAIL stall_resume%0d got v=%b d=%h want v=1 d=%h",
                         i, pcmValid, pcmOut, exp);
            end else if (i == 2 && pcmValid !== 1'b0) begin
                failures++;
                $display("FAIL stall_end got v=%b want 0", pcmValid);
            end
        end
    endtask

    task automatic test_overflow;
        int n;
        int bad;
        do_reset;
        pcmReady = 1'b0;
        // Serializer register takes beat 0, so 8 more fill the FIFO.
        for (int i = 0; i < 8; i++) begin
            inValid = 1'b1;
            dataBusIn = beat(i);
            tick;
        end
        checks++;
        if (inReady !== 1'b1) begin
            failures++;
            $display("FAIL ovf_ready_after8 got %b want 1", inReady);
        end
        dataBusIn = beat(8);
        tick;
        checks++;
        if ({inReady, overflow} !== 2'b00) begin
            failures++;
            $display("FAIL ovf_full got rdy=%b ovf=%b want 0 0", inReady, overflow);
        end
        dataBusIn = beat(9);
        tick;
        inValid = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_pulse got %b want 1", overflow);
        end
`ifdef PCM_DROP_COUNT_EN
        checks++;
        if (dropCount !== 8'd1) begin
            failures++;
            $display("FAIL ovf_dropCount got %0d want 1", dropCount);
        end
`endif
        tick;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_pulse_end got %b want 0", overflow);
        end
        pcmReady = 1'b1;
        n = 0;
        bad = 0;
        for (int c = 0; c < 80; c++) begin
            if (pcmValid) begin
                if (pcmOut !== 16'(n + 1)) bad++;
                n++;
            end
            tick;
        end
        checks++;
        if (n != 36) begin
            failures++;
            $display("FAIL ovf_drain_count got %0d want 36", n);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL ovf_drain_data got %0d bad want 0", bad);
        end
    endtask

    task automatic test_frame;
        int n;
        int bad;
        int ends;
        int endPos;
        do_reset;
        pcmReady = 1'b1;
        n = 0;
        bad = 0;
        ends = 0;
        endPos = -1;
        fork
            begin
                logic acc;
                int guard;
                for (int b = 0; b < 257; b++) begin
                    inValid = 1'b1;
                    dataBusIn = {16'(4*b + 3), 16'(4*b + 2),
                                 16'(4*b + 1), 16'(4*b)};
                    guard = 0;
                    do begin
                        acc = inReady;
                        tick;
                        guard++;
                    end while (!acc && guard < 100);
                end
                inValid = 1'b0;
            end
            begin
                for (int c = 0; c < 1200; c++) begin
                    if (pcmValid) begin
                        if (pcmOut !== 16'(n)) bad++;
                        if (frameEnd) begin
                            ends++;
                            if (endPos < 0) endPos = n;
                        end
                        n++;
                    end else if (frameEnd) begin
                        bad++;
                    end
                    tick;
                end
            end
        join
        checks++;
        if (n != 1028) begin
            failures++;
            $display("FAIL frame_samples got %0d want 1028", n);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL frame_data got %0d bad want 0", bad);
        end
        checks++;
        if (ends != 1) begin
            failures++;
            $display("FAIL frame_end_count got %0d want 1", ends);
        end
        checks++;
        if (endPos != 1023) begin
            failures++;
            $display("FAIL frame_end_pos got %0d want 1023", endPos);
        end
    endtask

    task automatic test_reset_mid;
        int stale;
        do_reset;
        pcmReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            inValid = 1'b1;
            dataBusIn = beat(20 + i);
            tick;
        end
        inValid = 1'b0;
        pcmReady = 1'b1;
        tick;
        tick;
        checks++;
        if ({pcmValid, pcmOut} !== {1'b1, 16'd83}) begin
            failures++;
            $display("FAIL rmid_lane2 got v=%b d=%0d want v=1 d=83", pcmValid, pcmOut);
        end
        reset = 1'b1;
        tick;
        checks++;
        if ({pcmValid, inReady, frameEnd} !== 3'b010) begin
            failures++;
            $display("FAIL rmid_after got v=%b rdy=%b fe=%b want 0 1 0",
                     pcmValid, inReady, frameEnd);
        end
        reset = 1'b0;
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            tick;
            if (pcmValid) stale++;
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("FAIL rmid_stale got %0d valid cycles want 0", stale);
        end
    endtask

    task automatic test_continuous;
        int n;
        int bad;
        int bubbles;
        do_reset;
        pcmReady = 1'b1;
        n = 0;
        bad = 0;
        bubbles = 0;
        for (int c = 0; c < 30; c++) begin
            inValid = (c % 4 == 0) && (c < 24);
            dataBusIn = beat(64 + c / 4);
            if (c >= 2 && c <= 25) begin
                if (!pcmValid) bubbles++;
                else if (pcmOut !== 16'(257 + c - 2)) bad++;
            end
            if (!inReady) bad++;
            if (pcmValid) n++;
            tick;
        end
        inValid = 1'b0;
        checks++;
        if (bubbles != 0) begin
            failures++;
            $display("FAIL cont_bubbles got %0d want 0", bubbles);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL cont_data got %0d bad want 0", bad);
        end
        checks++;
        if (n != 24) begin
            failures++;
            $display("FAIL cont_count got %0d want 24", n);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_backpressure;
        test_overflow;
        test_frame;
        test_reset_mid;
        test_continuous;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
